// File: rtl/dadda_product_accumulator.sv
// dadda_product_accumulator
// Back end of the 16x16 Dadda multiplier: sums a burst of unsigned products
// (dot-product / MAC style) and returns one result per burst over valid/ready.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   clr             synchronous abort; drops the current burst, returns to IDLE
//   prod_valid/prod_ready/prod_last/prod_data
//                   input product stream (unregistered multiplier output)
//   acc_valid/acc_ready
//                   result handshake; result held until accepted
//   acc_data        accumulated sum (ACC_W bits)
//   acc_ovf         sticky carry-out flag for the burst
//   acc_count       accepted products this burst, saturating
//
// Build option
//   DADDA_ACC_SAT_EN  defined: accumulator saturates at all-ones on carry-out.
//                     undefined: accumulator wraps modulo 2^ACC_W.

module dadda_product_accumulator #(
  parameter int unsigned PROD_W = 33,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              prod_last,
  input  logic [PROD_W-1:0] prod_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_ovf,
  output logic [CNT_W-1:0]  acc_count
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned PAD_W = SUM_W - PROD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic prod_ready_nxt;
  logic acc_valid_nxt;

  logic             in_xfer;
  logic             out_xfer;
  logic [SUM_W-1:0] sum_c;
  logic [ACC_W-1:0] acc_nxt;

  assign in_xfer  = prod_valid & prod_ready;
  assign out_xfer = acc_valid & acc_ready;

  // One extra bit of headroom exposes the carry-out for the overflow flag.
  assign sum_c = {1'b0, acc_data} + {{PAD_W{1'b0}}, prod_data};

`ifdef DADDA_ACC_SAT_EN
  // Once pinned at all-ones any further add carries out again, so it stays there.
  assign acc_nxt = sum_c[ACC_W] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
  assign acc_nxt = sum_c[ACC_W-1:0];
`endif

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prod_ready <= 1'b1;
      acc_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      prod_ready <= prod_ready_nxt;
      acc_valid  <= acc_valid_nxt;
    end
  end

  // Next-state logic; clr overrides every handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          state_nxt = prod_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_xfer && prod_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_xfer) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
    end
  end

  // Output decode: input side stalls only while a result is pending.
  always_comb begin
    prod_ready_nxt = 1'b1;
    acc_valid_nxt  = 1'b0;
    if (state_nxt == DONE) begin
      prod_ready_nxt = 1'b0;
      acc_valid_nxt  = 1'b1;
    end
  end

  // Datapath: sum, sticky overflow and saturating term count. A handshake on
  // the result clears everything so IDLE always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr || out_xfer) begin
      acc_data  <= '0;
      acc_ovf   <= 1'b0;
      acc_count <= '0;
    end else if (in_xfer) begin
      acc_data <= acc_nxt;
      acc_ovf  <= acc_ovf | sum_c[ACC_W];
      if (acc_count != {CNT_W{1'b1}}) begin
        acc_count <= acc_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Scoreboard bench for dadda_product_accumulator. Two instances share one
// stimulus stream: A at the default 40-bit width, B at ACC_W=34 so the
// overflow case is reachable with 33-bit products.

module tb_dadda_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        prod_valid;
  logic        prod_last;
  logic [32:0] prod_data;
  logic        acc_ready;

  logic        prod_ready_a, acc_valid_a, acc_ovf_a;
  logic [39:0] acc_data_a;
  logic [7:0]  acc_count_a;

  logic        prod_ready_b, acc_valid_b, acc_ovf_b;
  logic [33:0] acc_data_b;
  logic [7:0]  acc_count_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [39:0] data;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_a_t;

  typedef struct {
    logic [33:0] data;
    logic        ovf;
    logic [7:0]  cnt;
  } exp_b_t;

  exp_a_t q_a[$];
  exp_b_t q_b[$];

`ifdef DADDA_ACC_SAT_EN
  localparam logic [33:0] B_OVF_DATA = 34'h3_FFFF_FFFF;
`else
  localparam logic [33:0] B_OVF_DATA = 34'h0_FFFC_0002;
`endif

  always #5 clk = ~clk;

  dadda_product_accumulator u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready_a),
    .prod_last  (prod_last),
    .prod_data  (prod_data),
    .acc_valid  (acc_valid_a),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data_a),
    .acc_ovf    (acc_ovf_a),
    .acc_count  (acc_count_a)
  );

  dadda_product_accumulator #(.ACC_W(34)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready_b),
    .prod_last  (prod_last),
    .prod_data  (prod_data),
    .acc_valid  (acc_valid_b),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data_b),
    .acc_ovf    (acc_ovf_b),
    .acc_count  (acc_count_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [39:0] da, input logic oa,
                      input logic [33:0] db, input logic ob, input logic [7:0] c);
    exp_a_t ea;
    exp_b_t eb;
    ea.data = da; ea.ovf = oa; ea.cnt = c;
    eb.data = db; eb.ovf = ob; eb.cnt = c;
    q_a.push_back(ea);
    q_b.push_back(eb);
  endtask

  // Present one product and hold it until accepted (bounded wait).
  task automatic send(input logic [32:0] d, input logic l);
    int n;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = l;
    n = 0;
    while (prod_ready_a !== 1'b1 && n <= 50) begin
      @(negedge clk);
      if (prod_ready_a !== 1'b1) n++;
    end
    if (n > 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: prod_ready stayed 0x%0h expected 0x1", prod_ready_a);
    end
    @(negedge clk);
    chk("accept_ready_a", 64'(prod_ready_a), 64'h1);
    chk("accept_ready_b", 64'(prod_ready_b), 64'h1);
    chk("valid_low_on_accept", 64'(acc_valid_a), 64'h0);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  // Monitor A: pop and compare on every result handshake.
  initial begin
    exp_a_t e;
    forever begin
      @(negedge clk);
      if (acc_valid_a === 1'b1 && acc_ready === 1'b1) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result_a: got data 0x%0h expected no result", acc_data_a);
        end else begin
          e = q_a.pop_front();
          chk("a_data",  64'(acc_data_a),  64'(e.data));
          chk("a_ovf",   64'(acc_ovf_a),   64'(e.ovf));
          chk("a_count", 64'(acc_count_a), 64'(e.cnt));
        end
      end
    end
  end

  // Monitor B: same for the narrow accumulator.
  initial begin
    exp_b_t e;
    forever begin
      @(negedge clk);
      if (acc_valid_b === 1'b1 && acc_ready === 1'b1) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result_b: got data 0x%0h expected no result", acc_data_b);
        end else begin
          e = q_b.pop_front();
          chk("b_data",  64'(acc_data_b),  64'(e.data));
          chk("b_ovf",   64'(acc_ovf_b),   64'(e.ovf));
          chk("b_count", 64'(acc_count_b), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time 0x%0h expected completion earlier", $time);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    clr        = 1'b0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    prod_data  = '0;
    acc_ready  = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prod_ready", 64'(prod_ready_a), 64'h1);
    chk("rst_acc_valid",  64'(acc_valid_a),  64'h0);
    chk("rst_acc_data",   64'(acc_data_a),   64'h0);
    chk("rst_acc_ovf",    64'(acc_ovf_a),    64'h0);
    chk("rst_acc_count",  64'(acc_count_a),  64'h0);
    chk("rst_acc_valid_b", 64'(acc_valid_b), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 5 + 7 + 9 with result valid right after the last edge
    push(40'd21, 1'b0, 34'd21, 1'b0, 8'd3);
    send(33'd5, 1'b0);
    send(33'd7, 1'b0);
    send(33'd9, 1'b1);
    chk("latency_valid", 64'(acc_valid_a), 64'h1);
    chk("done_ready_low", 64'(prod_ready_a), 64'h0);
    @(posedge clk);
    #1;
    chk("post_hs_valid", 64'(acc_valid_a), 64'h0);
    chk("post_hs_data",  64'(acc_data_a),  64'h0);
    chk("post_hs_count", 64'(acc_count_a), 64'h0);

    // Single-term burst straight from IDLE to DONE
    push(40'h1_FFFE_0001, 1'b0, 34'h1_FFFE_0001, 1'b0, 8'd1);
    send(33'h1_FFFE_0001, 1'b1);
    chk("single_valid", 64'(acc_valid_a), 64'h1);
    @(posedge clk);
    #1;

    // Backpressure: result held 5 cycles, next burst only after the handshake
    acc_ready = 1'b0;
    push(40'd300, 1'b0, 34'd300, 1'b0, 8'd2);
    send(33'd100, 1'b0);
    send(33'd200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_prod_ready", 64'(prod_ready_a), 64'h0);
      chk("bp_acc_valid",  64'(acc_valid_a),  64'h1);
      chk("bp_acc_data",   64'(acc_data_a),   64'd300);
    end
    @(posedge clk);
    #1;
    acc_ready  = 1'b1;
    prod_valid = 1'b1;
    prod_data  = 33'd8;
    prod_last  = 1'b1;
    push(40'd8, 1'b0, 34'd8, 1'b0, 8'd1);
    @(negedge clk);
    chk("hs_cycle_ready", 64'(prod_ready_a), 64'h0);
    @(posedge clk);
    #1;
    chk("turnaround_valid", 64'(acc_valid_a), 64'h0);
    chk("turnaround_ready", 64'(prod_ready_a), 64'h1);
    chk("turnaround_count", 64'(acc_count_a), 64'h0);
    @(posedge clk);
    #1;
    chk("next_burst_valid", 64'(acc_valid_a), 64'h1);
    chk("next_burst_data",  64'(acc_data_a),  64'd8);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    @(posedge clk);
    #1;

    // Two max products: fits in 34 bits, no carry-out
    push(40'h3_FFFC_0002, 1'b0, 34'h3_FFFC_0002, 1'b0, 8'd2);
    send(33'h1_FFFE_0001, 1'b0);
    send(33'h1_FFFE_0001, 1'b1);
    @(posedge clk);
    #1;

    // Third term 2^32 carries out of the 34-bit accumulator only
    push(40'h4_FFFC_0002, 1'b0, B_OVF_DATA, 1'b1, 8'd3);
    send(33'h1_FFFE_0001, 1'b0);
    send(33'h1_FFFE_0001, 1'b0);
    send(33'h1_0000_0000, 1'b1);
    @(posedge clk);
    #1;

    // clr with a coincident product transfer drops the burst and the product
    send(33'd10, 1'b0);
    send(33'd20, 1'b0);
    chk("mid_burst_sum", 64'(acc_data_a), 64'd30);
    prod_valid = 1'b1;
    prod_data  = 33'd30;
    clr        = 1'b1;
    @(posedge clk);
    #1;
    clr        = 1'b0;
    prod_valid = 1'b0;
    chk("clr_valid", 64'(acc_valid_a), 64'h0);
    chk("clr_ready", 64'(prod_ready_a), 64'h1);
    chk("clr_data",  64'(acc_data_a),  64'h0);
    chk("clr_data_b", 64'(acc_data_b), 64'h0);
    chk("clr_count", 64'(acc_count_a), 64'h0);
    push(40'd4, 1'b0, 34'd4, 1'b0, 8'd1);
    send(33'd4, 1'b1);
    @(posedge clk);
    #1;

    // Reset mid-burst: burst discarded, no result emitted
    send(33'd50, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(acc_valid_a), 64'h0);
    chk("mid_rst_data",  64'(acc_data_a),  64'h0);
    chk("mid_rst_count", 64'(acc_count_a), 64'h0);
    repeat (3) @(posedge clk);
    #1;

    // 260 ones: count saturates at 255, sum keeps going
    push(40'd260, 1'b0, 34'd260, 1'b0, 8'd255);
    for (int i = 0; i < 260; i++) begin
      send(33'd1, (i == 259) ? 1'b1 : 1'b0);
    end
    @(posedge clk);
    #1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_a_drained", 64'(q_a.size()), 64'h0);
    chk("queue_b_drained", 64'(q_b.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
